minc_ram_arb: RTL

MINC_RAM_ARB -- requirements
Module: minc_ram_arb

---
 rtl/minc_ram_arb.sv | 132 +++++++++++++
 1 files changed

// File: rtl/minc_ram_arb.sv
// minc_ram_arb: two-requester arbiter in front of a 256x8 synchronous single-port RAM.
// Latency: grant in IDLE, RAM access in ACCESS, one-cycle ack pulse in RESP (3 cycles per transaction).
// Backpressure: requesters hold req until their ack; a loser simply stays pending in IDLE.
// Ports: CLK/RESET (async, active-high); c_* CPU command/ack/rdata; d_* debug command/ack/rdata;
//        mem_* RAM command, mem_rdata RAM read data; busy (not IDLE); owner (0=CPU, 1=debug).
// Option: define MINC_RAM_ARB_RR_EN for round-robin on simultaneous requests (default: CPU priority).
module minc_ram_arb (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       c_req,
  input  logic       c_we,
  input  logic [7:0] c_addr,
  input  logic [7:0] c_wdata,
  output logic       c_ack,
  output logic [7:0] c_rdata,
  input  logic       d_req,
  input  logic       d_we,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  output logic       d_ack,
  output logic [7:0] d_rdata,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t     state, state_nxt;
  logic       grant;
  logic       winner;      // 0 = CPU, 1 = debug; only meaningful when grant is high
  logic       owner_q;
  logic       lat_we;
  logic [7:0] lat_addr;
  logic [7:0] lat_wdata;
  logic [7:0] c_rdata_q;
  logic [7:0] d_rdata_q;

  assign grant = (state == IDLE) && (c_req || d_req);

`ifdef MINC_RAM_ARB_RR_EN
  // Pointer names the port that wins the next tie; reset favours debug.
  logic rr_dbg_next;

  assign winner = (c_req && d_req) ? rr_dbg_next : d_req;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)      rr_dbg_next <= 1'b1;
    else if (grant) rr_dbg_next <= ~winner;
  end
`else
  // CPU wins whenever it asks; debug only gets the RAM when the CPU is quiet.
  assign winner = ~c_req;
`endif

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command is captured at grant so later field changes or req drops are ignored.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      owner_q   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 8'h00;
      lat_wdata <= 8'h00;
      c_rdata_q <= 8'h00;
      d_rdata_q <= 8'h00;
    end else begin
      if (grant) begin
        owner_q   <= winner;
        lat_we    <= winner ? d_we    : c_we;
        lat_addr  <= winner ? d_addr  : c_addr;
        lat_wdata <= winner ? d_wdata : c_wdata;
      end
      // Capture read data at the end of the ack cycle so it holds until the next read ack.
      if (state == RESP && !lat_we) begin
        if (owner_q) d_rdata_q <= mem_rdata;
        else         c_rdata_q <= mem_rdata;
      end
    end
  end

  // Output logic
  always_comb begin
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    c_ack   = 1'b0;
    d_ack   = 1'b0;
    c_rdata = c_rdata_q;
    d_rdata = d_rdata_q;
    case (state)
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = lat_we;
      end
      RESP: begin
        c_ack = ~owner_q;
        d_ack = owner_q;
        // RAM data arrives in this cycle; pass it straight through so it is visible with ack.
        if (!lat_we) begin
          if (owner_q) d_rdata = mem_rdata;
          else         c_rdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign owner     = owner_q;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

endmodule
